view_ray_gen: RTL and testbench

- Frame-scanning, parametrised successor to the per-pixel view-ray unit.
- On `start`, latches the view normal and view distance, then computes |d| once with an iterative integer square root.
- Raster-scans the whole canvas, producing one view-ray vector per pixel through a shared sequential divider.
- Rays go to the downstream tracer stage over a valid/ready stream with row/col tags and an end-of-frame marker.

---
 rtl/view_ray_gen.sv | 235 +++++++++++++++++++++++
 tb/tb_view_ray_gen.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/view_ray_gen.sv
// Frame-scanning view-ray generator: computes |d| once per frame, then raster-scans the canvas,
// emitting one saturated view-ray per pixel through a shared sequential divider.
module view_ray_gen #(
   parameter int unsigned NXY_W    = 11,
   parameter int unsigned NZ_W     = 9,
   parameter int unsigned DIST_W   = 8,
   parameter int unsigned COL_BITS = 7,
   parameter int unsigned ROW_BITS = 6,
   parameter int unsigned OUT_XY_W = 11,
   parameter int unsigned OUT_Z_W  = 9
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic [2*NXY_W+NZ_W-1:0]           view_normal,
   input  logic [DIST_W-1:0]                 view_dist,
   output logic                              busy,
   output logic                              err_zero,
   output logic                              ray_valid,
   input  logic                              ray_ready,
   output logic [2*OUT_XY_W+OUT_Z_W-1:0]     ray_out,
   output logic [COL_BITS-1:0]               ray_col,
   output logic [ROW_BITS-1:0]               ray_row,
   output logic                              ray_last
);

   localparam int unsigned SqSteps = (2 * NXY_W + 3) / 2;
   localparam int unsigned SqOpW   = 2 * SqSteps;
   localparam int unsigned SqExtW  = SqOpW + 1;
   localparam int unsigned LenW    = SqSteps;
   localparam int unsigned RemW    = LenW + 2;
   localparam int unsigned ProdDW  = DIST_W + NXY_W - 1;
   localparam int unsigned ProdUW  = COL_BITS + NXY_W - 2;
   localparam int unsigned NumW    = ((ProdDW > ProdUW) ? ProdDW : ProdUW) + 1;
   localparam int unsigned NsW     = NumW + 1;
   localparam int unsigned CntW    = $clog2(NumW + SqSteps + 1);

   localparam logic [NumW-1:0] SatPos = NumW'((64'd1 << (OUT_XY_W - 1)) - 64'd1);
   localparam logic [NumW-1:0] SatNeg = NumW'(64'd1 << (OUT_XY_W - 1));

   typedef enum logic [2:0] {StIdle, StSqrt, StPix, StDiv, StOut} state_e;

   // One restoring-division step: shift in the numerator MSB, subtract divisor if it fits.
   function automatic logic [LenW+NumW-1:0] div_step(input logic [LenW-1:0] rem,
                                                     input logic [NumW-1:0] num,
                                                     input logic [LenW-1:0] den);
      logic [LenW:0] sh;
      sh = {rem, num[NumW-1]};
      if (sh >= {1'b0, den}) begin
         return {LenW'(sh - {1'b0, den}), num[NumW-2:0], 1'b1};
      end
      return {sh[LenW-1:0], num[NumW-2:0], 1'b0};
   endfunction

   function automatic logic [OUT_XY_W-1:0] sat_q(input logic [NumW-1:0] q, input logic neg);
      if (!neg) begin
         return (q > SatPos) ? {1'b0, {(OUT_XY_W-1){1'b1}}} : OUT_XY_W'(q);
      end
      return (q > SatNeg) ? {1'b1, {(OUT_XY_W-1){1'b0}}} : OUT_XY_W'(NumW'(0) - q);
   endfunction

   state_e                   state_q;
   logic signed [NXY_W-1:0]  dx_q, dy_q;
   logic [DIST_W-1:0]        d0_q;
   logic [COL_BITS-1:0]      col_q;
   logic [ROW_BITS-1:0]      row_q;
   logic [CntW-1:0]          cnt_q;
   logic [SqOpW-1:0]         sq_op_q;
   logic [RemW-1:0]          sq_rem_q;
   logic [LenW-1:0]          sq_root_q;
   logic [NumW-1:0]          nx_num_q, ny_num_q;
   logic [LenW-1:0]          nx_rem_q, ny_rem_q;
   logic                     nx_neg_q, ny_neg_q;

   logic signed [NXY_W-1:0]  in_dx, in_dy;
   logic signed [NZ_W-1:0]   in_dz;
   logic signed [SqExtW-1:0] ext_x, ext_y, ext_z, sum_sq;
   logic [RemW+1:0]          sq_shift, sq_trial;
   logic [RemW-1:0]          sq_rem_nxt;
   logic [LenW-1:0]          sq_root_nxt;
   logic [NumW-1:0]          nx_num_nxt, ny_num_nxt;
   logic [LenW-1:0]          nx_rem_nxt, ny_rem_nxt;
   logic signed [COL_BITS-1:0] u;
   logic signed [ROW_BITS-1:0] v;
   logic signed [NsW-1:0]    d0_s, dx_s, dy_s, u_s, nx, ny;
   logic [NumW-1:0]          nx_mag, ny_mag;
   logic [OUT_XY_W-1:0]      rx_sat, ry_sat;
   logic [OUT_Z_W-1:0]       rz_ext;
   logic                     pix_last;

   assign {in_dx, in_dy, in_dz} = view_normal;
   assign ext_x  = SqExtW'(in_dx);
   assign ext_y  = SqExtW'(in_dy);
   assign ext_z  = SqExtW'(in_dz);
   assign sum_sq = ext_x * ext_x + ext_y * ext_y + ext_z * ext_z;

   // Bit-pair restoring square root: two operand bits consumed per cycle.
   always_comb begin
      sq_shift    = {sq_rem_q, sq_op_q[SqOpW-1 -: 2]};
      sq_trial    = {2'b00, sq_root_q, 2'b01};
      sq_rem_nxt  = sq_shift[RemW-1:0];
      sq_root_nxt = {sq_root_q[LenW-2:0], 1'b0};
      if (sq_shift >= sq_trial) begin
         sq_rem_nxt  = RemW'(sq_shift - sq_trial);
         sq_root_nxt = {sq_root_q[LenW-2:0], 1'b1};
      end
   end

   assign {nx_rem_nxt, nx_num_nxt} = div_step(nx_rem_q, nx_num_q, sq_root_q);
   assign {ny_rem_nxt, ny_num_nxt} = div_step(ny_rem_q, ny_num_q, sq_root_q);

   // u = col - 2^(COL_BITS-1) and v = 2^(ROW_BITS-1)-1 - row reduce to MSB/bit inversions.
   assign u = {~col_q[COL_BITS-1], col_q[COL_BITS-2:0]};
   assign v = {row_q[ROW_BITS-1], ~row_q[ROW_BITS-2:0]};

   assign d0_s   = NsW'(d0_q);
   assign dx_s   = NsW'(dx_q);
   assign dy_s   = NsW'(dy_q);
   assign u_s    = NsW'(u);
   assign nx     = d0_s * dx_s - u_s * dy_s;
   assign ny     = d0_s * dy_s + u_s * dx_s;
   assign nx_mag = nx[NsW-1] ? NumW'(-nx) : NumW'(nx);
   assign ny_mag = ny[NsW-1] ? NumW'(-ny) : NumW'(ny);

   assign rx_sat   = sat_q(nx_num_nxt, nx_neg_q);
   assign ry_sat   = sat_q(ny_num_nxt, ny_neg_q);
   assign rz_ext   = OUT_Z_W'(v);
   assign pix_last = (&col_q) & (&row_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         busy      <= 1'b0;
         err_zero  <= 1'b0;
         ray_valid <= 1'b0;
         ray_out   <= '0;
         ray_col   <= '0;
         ray_row   <= '0;
         ray_last  <= 1'b0;
         dx_q      <= '0;
         dy_q      <= '0;
         d0_q      <= '0;
         col_q     <= '0;
         row_q     <= '0;
         cnt_q     <= '0;
         sq_op_q   <= '0;
         sq_rem_q  <= '0;
         sq_root_q <= '0;
         nx_num_q  <= '0;
         ny_num_q  <= '0;
         nx_rem_q  <= '0;
         ny_rem_q  <= '0;
         nx_neg_q  <= 1'b0;
         ny_neg_q  <= 1'b0;
      end else begin
         err_zero <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  dx_q      <= in_dx;
                  dy_q      <= in_dy;
                  d0_q      <= view_dist;
                  col_q     <= '0;
                  row_q     <= '0;
                  cnt_q     <= '0;
                  sq_op_q   <= SqOpW'(sum_sq);
                  sq_rem_q  <= '0;
                  sq_root_q <= '0;
                  busy      <= 1'b1;
                  state_q   <= StSqrt;
               end
            end
            StSqrt: begin
               sq_op_q   <= {sq_op_q[SqOpW-3:0], 2'b00};
               sq_rem_q  <= sq_rem_nxt;
               sq_root_q <= sq_root_nxt;
               cnt_q     <= cnt_q + CntW'(1);
               if (cnt_q == CntW'(SqSteps - 1)) begin
                  cnt_q <= '0;
                  if (sq_root_nxt == '0) begin
                     err_zero <= 1'b1;
                     busy     <= 1'b0;
                     state_q  <= StIdle;
                  end else begin
                     state_q <= StPix;
                  end
               end
            end
            StPix: begin
               nx_num_q <= nx_mag;
               ny_num_q <= ny_mag;
               nx_neg_q <= nx[NsW-1];
               ny_neg_q <= ny[NsW-1];
               nx_rem_q <= '0;
               ny_rem_q <= '0;
               cnt_q    <= '0;
               state_q  <= StDiv;
            end
            StDiv: begin
               nx_num_q <= nx_num_nxt;
               ny_num_q <= ny_num_nxt;
               nx_rem_q <= nx_rem_nxt;
               ny_rem_q <= ny_rem_nxt;
               cnt_q    <= cnt_q + CntW'(1);
               if (cnt_q == CntW'(NumW - 1)) begin
                  cnt_q     <= '0;
                  ray_out   <= {rx_sat, ry_sat, rz_ext};
                  ray_col   <= col_q;
                  ray_row   <= row_q;
                  ray_last  <= pix_last;
                  ray_valid <= 1'b1;
                  state_q   <= StOut;
               end
            end
            StOut: begin
               if (ray_ready) begin
                  ray_valid <= 1'b0;
                  if (ray_last) begin
                     busy    <= 1'b0;
                     state_q <= StIdle;
                  end else begin
                     col_q <= col_q + COL_BITS'(1);
                     if (&col_q) begin
                        row_q <= row_q + ROW_BITS'(1);
                     end
                     state_q <= StPix;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_view_ray_gen.sv
// Self-checking bench for view_ray_gen on a reduced canvas, with a second instance using a
// narrow ray width to exercise quotient saturation.
module tb_view_ray_gen;

   localparam int unsigned NXY  = 11;
   localparam int unsigned NZ   = 9;
   localparam int unsigned DW   = 8;
   localparam int unsigned CB   = 4;
   localparam int unsigned RB   = 3;
   localparam int unsigned OXY  = 11;
   localparam int unsigned OXY8 = 8;
   localparam int unsigned OZ   = 9;
   localparam int unsigned NW   = 2 * NXY + NZ;
   localparam int NCOL   = 1 << CB;
   localparam int NROW   = 1 << RB;
   localparam int NPIX   = NCOL * NROW;
   localparam int BUDGET = 20000;

   logic                      clk;
   logic                      rst_n;
   logic                      start;
   logic [NW-1:0]             view_normal;
   logic [DW-1:0]             view_dist;
   logic                      ray_ready;
   logic                      busy, err_zero, ray_valid, ray_last;
   logic [2*OXY+OZ-1:0]       ray_out;
   logic [CB-1:0]             ray_col;
   logic [RB-1:0]             ray_row;
   logic                      busy8, err8, valid8, last8;
   logic [2*OXY8+OZ-1:0]      out8;
   logic [CB-1:0]             col8;
   logic [RB-1:0]             row8;

   int n_checks;
   int n_fail;
   longint m_dx, m_dy, m_d0, m_len;

   view_ray_gen #(.NXY_W(NXY), .NZ_W(NZ), .DIST_W(DW), .COL_BITS(CB), .ROW_BITS(RB),
                  .OUT_XY_W(OXY), .OUT_Z_W(OZ)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .view_normal(view_normal),
      .view_dist(view_dist), .busy(busy), .err_zero(err_zero), .ray_valid(ray_valid),
      .ray_ready(ray_ready), .ray_out(ray_out), .ray_col(ray_col), .ray_row(ray_row),
      .ray_last(ray_last));

   view_ray_gen #(.NXY_W(NXY), .NZ_W(NZ), .DIST_W(DW), .COL_BITS(CB), .ROW_BITS(RB),
                  .OUT_XY_W(OXY8), .OUT_Z_W(OZ)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start), .view_normal(view_normal),
      .view_dist(view_dist), .busy(busy8), .err_zero(err8), .ray_valid(valid8),
      .ray_ready(ray_ready), .ray_out(out8), .ray_col(col8), .ray_row(row8),
      .ray_last(last8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic longint isqrt(input longint s);
      longint r = 0;
      while ((r + 1) * (r + 1) <= s) r++;
      return r;
   endfunction

   function automatic longint sat(input longint q, input int w);
      longint hi = (longint'(1) << (w - 1)) - 1;
      longint lo = -hi - 1;
      if (q > hi) return hi;
      if (q < lo) return lo;
      return q;
   endfunction

   function automatic longint exp_rx(input int col, input int w);
      longint u = longint'(col) - NCOL / 2;
      return sat((m_d0 * m_dx - u * m_dy) / m_len, w);
   endfunction

   function automatic longint exp_ry(input int col, input int w);
      longint u = longint'(col) - NCOL / 2;
      return sat((m_d0 * m_dy + u * m_dx) / m_len, w);
   endfunction

   function automatic longint exp_rz(input int row);
      return longint'(NROW / 2 - 1 - row);
   endfunction

   task automatic set_frame(input int dx, input int dy, input int dz, input int d0);
      view_normal = {NXY'(dx), NXY'(dy), NZ'(dz)};
      view_dist   = DW'(d0);
      m_dx  = dx;
      m_dy  = dy;
      m_d0  = d0;
      m_len = isqrt(longint'(dx) * dx + longint'(dy) * dy + longint'(dz) * dz);
   endtask

   // Streams a full frame, checking each accepted ray against the model.
   task automatic run_frame(input string name, input int ready_pct, input bit poke,
                            input bit scramble);
      int got;
      int cyc;
      int e_col, e_row;
      bit e_last, held, late;
      logic [2*OXY+OZ-1:0] h_out;
      logic [CB-1:0] h_col;
      logic [RB-1:0] h_row;
      logic h_last;
      logic signed [OXY-1:0] a_rx, a_ry;
      logic signed [OZ-1:0] a_rz;
      logic signed [OXY8-1:0] b_rx, b_ry;
      got = 0;
      cyc = 0;
      held = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (scramble) begin
         view_normal = NW'($urandom);
         view_dist   = DW'($urandom);
      end
      while (got < NPIX && cyc < BUDGET) begin
         if (held) begin
            n_checks++;
            if (ray_valid !== 1'b1 || ray_out !== h_out || ray_col !== h_col ||
                ray_row !== h_row || ray_last !== h_last) begin
               n_fail++;
               $display("FAIL %s hold: got v=%b out=%h c=%0d r=%0d expected out=%h c=%0d r=%0d",
                        name, ray_valid, ray_out, ray_col, ray_row, h_out, h_col, h_row);
            end
         end
         ray_ready = (int'($urandom_range(99)) < ready_pct);
         start = (poke && (cyc == 500 || cyc == 1500));
         held = 0;
         if (ray_valid === 1'b1) begin
            if (ray_ready) begin
               e_col  = got % NCOL;
               e_row  = got / NCOL;
               e_last = (got == NPIX - 1);
               a_rx = ray_out[2*OXY+OZ-1 -: OXY];
               a_ry = ray_out[OXY+OZ-1 -: OXY];
               a_rz = ray_out[OZ-1:0];
               b_rx = out8[2*OXY8+OZ-1 -: OXY8];
               b_ry = out8[OXY8+OZ-1 -: OXY8];
               n_checks += 6;
               if ({ray_col, ray_row, ray_last} !== {CB'(e_col), RB'(e_row), e_last}) begin
                  n_fail++;
                  $display("FAIL %s tag: got c=%0d r=%0d l=%b expected c=%0d r=%0d l=%b",
                           name, ray_col, ray_row, ray_last, e_col, e_row, e_last);
               end
               if (longint'(a_rx) !== exp_rx(e_col, OXY)) begin
                  n_fail++;
                  $display("FAIL %s rx px%0d: got %0d expected %0d", name, got, a_rx,
                           exp_rx(e_col, OXY));
               end
               if (longint'(a_ry) !== exp_ry(e_col, OXY)) begin
                  n_fail++;
                  $display("FAIL %s ry px%0d: got %0d expected %0d", name, got, a_ry,
                           exp_ry(e_col, OXY));
               end
               if (longint'(a_rz) !== exp_rz(e_row)) begin
                  n_fail++;
                  $display("FAIL %s rz px%0d: got %0d expected %0d", name, got, a_rz,
                           exp_rz(e_row));
               end
               if (valid8 !== 1'b1 || longint'(b_rx) !== exp_rx(e_col, OXY8)) begin
                  n_fail++;
                  $display("FAIL %s rx8 px%0d: got %0d (v=%b) expected %0d", name, got, b_rx,
                           valid8, exp_rx(e_col, OXY8));
               end
               if (longint'(b_ry) !== exp_ry(e_col, OXY8)) begin
                  n_fail++;
                  $display("FAIL %s ry8 px%0d: got %0d expected %0d", name, got, b_ry,
                           exp_ry(e_col, OXY8));
               end
               got++;
            end else begin
               held   = 1;
               h_out  = ray_out;
               h_col  = ray_col;
               h_row  = ray_row;
               h_last = ray_last;
            end
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      n_checks++;
      if (got != NPIX) begin
         n_fail++;
         $display("FAIL %s count: got %0d rays expected %0d", name, got, NPIX);
      end
      n_checks++;
      if (busy !== 1'b0 || ray_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s end: got busy=%b valid=%b expected busy=0 valid=0", name, busy,
                  ray_valid);
      end
      ray_ready = 1'b1;
      late = 0;
      repeat (30) begin
         @(negedge clk);
         if (busy !== 1'b0 || ray_valid !== 1'b0) late = 1;
      end
      n_checks++;
      if (late) begin
         n_fail++;
         $display("FAIL %s idle: got activity after frame expected none", name);
      end
   endtask

   task automatic test_reset();
      n_checks++;
      if ({busy, err_zero, ray_valid, ray_out, ray_col, ray_row, ray_last} !== '0 ||
          {busy8, err8, valid8, out8, col8, row8, last8} !== '0) begin
         n_fail++;
         $display("FAIL reset: got busy=%b valid=%b out=%h expected all zero", busy, ray_valid,
                  ray_out);
      end
   endtask

   task automatic test_basic();
      set_frame(100, 0, 0, 50);
      run_frame("basic", 100, 0, 0);
      set_frame(3, 4, 0, 10);
      run_frame("trunc", 100, 0, 0);
   endtask

   task automatic test_saturation();
      set_frame(1023, 1023, 255, 255);
      run_frame("big", 100, 0, 0);
      set_frame(1, 0, 0, 255);
      run_frame("sat", 100, 0, 0);
   endtask

   task automatic test_err_zero();
      int pulses;
      bit saw_valid;
      bit was_busy;
      pulses = 0;
      saw_valid = 0;
      set_frame(0, 0, 0, 77);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      was_busy = busy;
      repeat (40) begin
         if (err_zero === 1'b1) pulses++;
         if (ray_valid === 1'b1) saw_valid = 1;
         @(negedge clk);
      end
      n_checks += 3;
      if (was_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL err_busy: got busy=%b expected 1", was_busy);
      end
      if (pulses != 1 || saw_valid) begin
         n_fail++;
         $display("FAIL err_pulse: got %0d pulses valid=%b expected 1 pulse valid=0", pulses,
                  saw_valid);
      end
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL err_idle: got busy=%b expected 0", busy);
      end
   endtask

   task automatic test_backpressure();
      set_frame(-517, 300, -100, 200);
      run_frame("bp", 50, 1, 1);
   endtask

   task automatic test_back_to_back();
      int dx, dy, dz, d0;
      for (int k = 0; k < 2; k++) begin
         dx = int'($urandom_range(2047)) - 1024;
         dy = int'($urandom_range(2047)) - 1024;
         dz = int'($urandom_range(511)) - 256;
         d0 = int'($urandom_range(255));
         if (dx == 0 && dy == 0 && dz == 0) dx = 1;
         set_frame(dx, dy, dz, d0);
         run_frame("rand", 70, 0, 1);
      end
   endtask

   task automatic test_reset_mid_frame();
      set_frame(100, 0, 0, 50);
      ray_ready = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (300) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, err_zero, ray_valid, ray_out, ray_col, ray_row, ray_last} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got busy=%b valid=%b out=%h col=%0d expected all zero",
                  busy, ray_valid, ray_out, ray_col);
      end
      @(negedge clk);
      rst_n = 1'b1;
      set_frame(3, 4, 0, 10);
      run_frame("after_reset", 100, 0, 0);
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      rst_n       = 1'b0;
      start       = 1'b0;
      ray_ready   = 1'b0;
      view_normal = '0;
      view_dist   = '0;
      #12;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_basic();
      test_saturation();
      test_err_zero();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
